// File: rtl/mul_div.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, 33-cycle latency, one-cycle done pulse with the 64-bit result.
//   state   | meaning
//   IDLE    | waiting for start_i; latches operand magnitudes and signs
//   CALC    | 32 iterations of shift-add or restoring-divide
//   DONE    | done_o high for one cycle with result_o valid
module mul_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        cancel_i,
  input  logic        mul_or_div_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        reg1_sign_i,
  input  logic        reg2_sign_i,
  output logic [63:0] result_o,
  output logic        done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  counter;
  logic        is_div;
  logic        neg_a;
  logic        neg_b;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [31:0] rem;
  logic [31:0] dq;

  logic        in_neg_a;
  logic        in_neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] acc_next;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        q_bit;
  logic [31:0] rem_next;
  logic [31:0] dq_next;
  logic [63:0] prod_final;
  logic [31:0] quot_final;
  logic [31:0] rem_final;

  assign in_neg_a = reg1_sign_i & dividend_i[31];
  assign in_neg_b = reg2_sign_i & divisor_i[31];
  assign mag_a    = in_neg_a ? (~dividend_i + 32'd1) : dividend_i;
  assign mag_b    = in_neg_b ? (~divisor_i + 32'd1) : divisor_i;

  assign acc_next = acc + (mplier[0] ? mcand : 64'd0);

  // dq holds the not-yet-consumed dividend bits on the left and the quotient
  // bits collected so far on the right.
  assign rem_shift = {rem, dq[31]};
  assign rem_diff  = rem_shift - {1'b0, mplier};
  assign q_bit     = ~rem_diff[32];
  assign rem_next  = q_bit ? rem_diff[31:0] : rem_shift[31:0];
  assign dq_next   = {dq[30:0], q_bit};

  assign prod_final = (neg_a ^ neg_b) ? (~acc_next + 64'd1) : acc_next;
  assign quot_final = (neg_a ^ neg_b) ? (~dq_next + 32'd1) : dq_next;
  assign rem_final  = neg_a ? (~rem_next + 32'd1) : rem_next;

  assign done_o = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      counter  <= 5'd0;
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      acc      <= 64'd0;
      mcand    <= 64'd0;
      mplier   <= 32'd0;
      rem      <= 32'd0;
      dq       <= 32'd0;
      result_o <= 64'd0;
    end else if (cancel_i) begin
      state   <= ST_IDLE;
      counter <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            is_div  <= mul_or_div_i;
            neg_a   <= in_neg_a;
            neg_b   <= in_neg_b;
            counter <= 5'd0;
            acc     <= 64'd0;
            mcand   <= {32'd0, mag_a};
            mplier  <= mag_b;
            rem     <= 32'd0;
            dq      <= mag_a;
            // Divide by zero bypasses the iteration with the raw dividend as remainder.
            if (mul_or_div_i && (divisor_i == 32'd0)) begin
              result_o <= {32'hFFFF_FFFF, dividend_i};
              state    <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          counter <= counter + 5'd1;
          if (is_div) begin
            rem <= rem_next;
            dq  <= dq_next;
          end else begin
            acc    <= acc_next;
            mcand  <= {mcand[62:0], 1'b0};
            mplier <= {1'b0, mplier[31:1]};
          end
          if (counter == 5'd31) begin
            result_o <= is_div ? {quot_final, rem_final} : prod_final;
            counter  <= 5'd0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div.sv
// Self-checking bench for mul_div: directed RV32M cases, cancel/reset scenarios
// and random operations checked against a plain-arithmetic reference model.
module tb_mul_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        cancel_i;
  logic        mul_or_div_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        reg1_sign_i;
  logic        reg2_sign_i;
  logic [63:0] result_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_exp;

  mul_div dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .cancel_i     (cancel_i),
    .mul_or_div_i (mul_or_div_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .reg1_sign_i  (reg1_sign_i),
    .reg2_sign_i  (reg2_sign_i),
    .result_o     (result_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_model(input logic div, input logic [31:0] a,
                                            input logic [31:0] b, input logic s1,
                                            input logic s2);
    logic [63:0] ea;
    logic [63:0] eb;
    longint      sa;
    longint      sb;
    logic [63:0] qv;
    logic [63:0] rv;
    ea = s1 ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s2 ? {{32{b[31]}}, b} : {32'd0, b};
    if (!div) return ea * eb;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    sa = ea;
    sb = eb;
    qv = sa / sb;
    rv = sa % sb;
    return {qv[31:0], rv[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count cycles from the current cycle until done_o is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic div, input logic [31:0] a,
                       input logic [31:0] b, input logic s1, input logic s2);
    logic [63:0] exp;
    int          lat;
    exp = ref_model(div, a, b, s1, s2);
    @(negedge clk);
    mul_or_div_i = div;
    dividend_i   = a;
    divisor_i    = b;
    reg1_sign_i  = s1;
    reg2_sign_i  = s2;
    start_i      = 1'b1;
    @(posedge clk); #1;
    dividend_i = $urandom;
    divisor_i  = $urandom;
    lat = 1;
    while (!done_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    start_i = 1'b0;
    check({tag, "_latency"}, 64'(lat), (div && b == 32'd0) ? 64'd1 : 64'd33);
    check({tag, "_result"}, result_o, exp);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {63'd0, done_o}, 64'd0);
    check({tag, "_hold"}, result_o, exp);
    last_exp = exp;
  endtask

  initial begin
    logic [63:0] exp;
    logic        saw_done;
    int          lat;
    logic        div;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; mul_or_div_i = 1'b0;
    dividend_i = 32'd0; divisor_i = 32'd0; reg1_sign_i = 1'b0; reg2_sign_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result_o, 64'd0);
    check("reset_done", {63'd0, done_o}, 64'd0);
    rst = 1'b0;
    last_exp = 64'd0;

    do_op("mul_7x6",      1'b0, 32'd7,          32'd6,          1'b0, 1'b0);
    do_op("mulh_m2x3",    1'b0, 32'hFFFF_FFFE,  32'd3,          1'b1, 1'b1);
    do_op("mulhsu_ff",    1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0);
    do_op("mulhu_ff",     1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0);
    do_op("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          1'b1, 1'b1);
    do_op("divu_100_7",   1'b1, 32'd100,        32'd7,          1'b0, 1'b0);
    do_op("div_overflow", 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1);
    do_op("div_5_0",      1'b1, 32'd5,          32'd0,          1'b1, 1'b1);
    do_op("div_m5_0",     1'b1, 32'hFFFF_FFFB,  32'd0,          1'b1, 1'b1);
    do_op("rem_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  1'b1, 1'b1);

    // Cancel a divide in cycle 10, restart in cycle 11.
    @(negedge clk);
    mul_or_div_i = 1'b1; dividend_i = 32'd1000; divisor_i = 32'd3;
    reg1_sign_i = 1'b1; reg2_sign_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    saw_done = 1'b0;
    repeat (9) begin
      if (done_o) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    cancel_i = 1'b1;
    @(posedge clk); #1;
    cancel_i = 1'b0;
    check("cancel_no_done", {62'd0, saw_done, done_o}, 64'd0);
    check("cancel_result_kept", result_o, last_exp);
    mul_or_div_i = 1'b0; dividend_i = 32'd12345; divisor_i = 32'hFFFF_FFFD;
    reg1_sign_i = 1'b1; reg2_sign_i = 1'b1;
    exp = ref_model(1'b0, 32'd12345, 32'hFFFF_FFFD, 1'b1, 1'b1);
    wait_done(lat);
    start_i = 1'b0;
    check("restart_latency", 64'(lat), 64'd33);
    check("restart_result", result_o, exp);
    last_exp = exp;
    @(posedge clk); #1;

    // Reset in cycle 20 of a multiply.
    @(negedge clk);
    mul_or_div_i = 1'b0; dividend_i = 32'hDEAD_BEEF; divisor_i = 32'h1234_5678;
    reg1_sign_i = 1'b0; reg2_sign_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (19) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start_i = 1'b0;
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    saw_done = 1'b0;
    repeat (20) begin
      if (done_o) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_no_late_done", {63'd0, saw_done}, 64'd0);
    check("rst_result_stays", result_o, 64'd0);

    for (int i = 0; i < 30; i++) begin
      div = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      do_op("rand", div, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div.md
# mul_div

Iterative multiply/divide unit for the RV32M instructions. It sits beside the execute stage. Execute drives start, operands and signedness for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, and holds them while the pipeline stalls. The unit returns a 64-bit result with a one-cycle done pulse. Execute selects the high word for DIV/DIVU/MULH*/MULHU and the low word for MUL/REM/REMU.

## Interface
- No parameters; widths come from `RegBus` (32) and `DoubleRegBus` (64) in yadan_defs.v.
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request; level, held by execute until done_o.
- cancel_i  input  1  flush (interrupt or branch): abort the current operation.
- mul_or_div_i  input  1  `MUL`=0 multiply, `DIV`=1 divide.
- dividend_i  input  32  operand 1 (multiplicand or dividend).
- divisor_i  input  32  operand 2 (multiplier or divisor).
- reg1_sign_i  input  1  `Signed`=1: operand 1 is two's complement.
- reg2_sign_i  input  1  `Signed`=1: operand 2 is two's complement.
- result_o  output  64  multiply: full product. Divide: {quotient[31:0], remainder[31:0]}.
- done_o  output  1  one-cycle pulse; result_o is valid in that cycle.

## Operation
- States: IDLE, CALC, DONE. Reset: state=IDLE, done_o=0, result_o=0, counter=0.
- **IDLE**
  - start_i=1 and cancel_i=0: latch magnitudes, result signs and the op, then go to CALC with counter=0.
  - Operand n is negative iff regn_sign_i and bit 31 are both 1; its magnitude is its two's-complement negation.
  - Divide with divisor_i==0: go straight to DONE with quotient=32'hFFFF_FFFF and remainder=dividend_i (raw, not negated).
- **CALC, multiply:** shift-add, one multiplier bit per cycle, LSB first, into a 64-bit accumulator.
- **CALC, divide:** restoring division, one quotient bit per cycle, MSB first.
  - Per step: shift the 33-bit partial remainder left, pull in the next dividend bit, subtract the divisor magnitude.
  - Keep the difference when it is non-negative and set the quotient bit to 1.
- **CALC exit:** after 32 iterations (counter==31), apply the signs and go to DONE with result_o registered.
  - Multiply: negate the 64-bit product iff exactly one operand is negative.
  - Divide: quotient is negated iff the operand signs differ. Remainder takes the sign of the dividend.
- **Overflow:** signed -2^31 / -1 falls out of the normal path as quotient=32'h8000_0000, remainder=0. No special case.
- **DONE:** done_o=1 for exactly one cycle, then IDLE. start_i is ignored in DONE.
- **result_o** holds its value until the next completion; it is not cleared on return to IDLE.
- **cancel_i=1 in any state:** go to IDLE next cycle, done_o=0, result_o unchanged.
  - A cancel in the DONE cycle does not suppress that cycle's done_o.
  - When cancel_i and start_i are both high in IDLE, cancel wins.
- **rst mid-operation:** IDLE next cycle, all outputs at reset values.

## Timing
- Cycle 0: IDLE with start_i=1; operands sampled at the end of the cycle.
- Cycles 1–32: CALC. Cycle 33: done_o=1 with the result. Total latency: 33 cycles from start to done.
- Divide-by-zero: done_o in cycle 1.
- Back-to-back: earliest next acceptance is cycle 34 (IDLE), if start_i is still high or re-asserted.
  - Execute drops start_i combinationally while done_o=1, so a request is never re-accepted in DONE.
- Operand inputs may change after cycle 0 without affecting the in-flight operation.

## Test plan
- MUL, unsigned: 0x0000_0007 × 0x0000_0006 -> done in cycle 33, result_o=64'h0000_0000_0000_002A. done_o high for exactly one cycle.
- MULH, both signed: 0xFFFF_FFFE (-2) × 0x0000_0003 -> result_o=64'hFFFF_FFFF_FFFF_FFFA.
- MULHSU (reg1 signed, reg2 unsigned): 0xFFFF_FFFF × 0xFFFF_FFFF -> result_o=64'hFFFF_FFFF_0000_0001.
- DIV/REM, signed: -7 / 2 -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF.
- DIVU: 100 / 7 -> {32'd14, 32'd2}.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF -> {32'h8000_0000, 32'h0}.
- Divide by zero: 5 / 0 signed -> {32'hFFFF_FFFF, 32'h5}, done_o in cycle 1.
- cancel_i at cycle 10 of a divide -> no done_o, state IDLE at cycle 11, result_o keeps its previous value. A new start in cycle 11 completes normally at cycle 44.
- rst asserted at cycle 20 -> done_o=0 and result_o=0 from cycle 21.
